// File: rtl/fetcher.sv
// Instruction fetch unit: issues a valid/ready read of program memory at the core PC and latches the returned word.
// Optional FETCHER_LAST_INST_CACHE_EN: skip the memory read when re-fetching the most recently fetched PC.
module fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [7:0]                       current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  state_t                           state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_adj;
  logic                             hit;

  // PC is 8 bits wide; truncate or zero-extend to the memory address width.
  generate
    if (PROGRAM_MEM_ADDR_BITS < 8) begin : g_pc_trunc
      assign pc_adj = current_pc[PROGRAM_MEM_ADDR_BITS-1:0];
    end else if (PROGRAM_MEM_ADDR_BITS == 8) begin : g_pc_same
      assign pc_adj = current_pc;
    end else begin : g_pc_ext
      assign pc_adj = {{(PROGRAM_MEM_ADDR_BITS-8){1'b0}}, current_pc};
    end
  endgenerate

`ifdef FETCHER_LAST_INST_CACHE_EN
  logic [7:0] tag;
  logic [7:0] req_pc;
  logic       tag_valid;

  assign hit = tag_valid && (tag == current_pc);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
`ifdef FETCHER_LAST_INST_CACHE_EN
      tag              <= '0;
      req_pc           <= '0;
      tag_valid        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (hit) begin
              state <= FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= pc_adj;
              state            <= FETCHING;
`ifdef FETCHER_LAST_INST_CACHE_EN
              req_pc           <= current_pc;
`endif
            end
          end
        end
        FETCHING: begin
          // No abort path: once issued, the read completes regardless of core_state.
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state          <= FETCHED;
`ifdef FETCHER_LAST_INST_CACHE_EN
            tag            <= req_pc;
            tag_valid      <= 1'b1;
`endif
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fetcher_state = state;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for fetcher; expected values are hand-computed per scenario.
module tb_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int checks = 0;
  int errors = 0;

  // {fetcher_state, mem_read_valid, mem_read_address, instruction}
  logic [27:0] obs;
  assign obs = {fetcher_state, mem_read_valid, mem_read_address, instruction};

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; core_state = 3'b000; current_pc = 8'h00;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    #12;
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h00, 16'h0000}) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs, {3'd0, 1'b0, 8'h00, 16'h0000});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    current_pc = 8'h05; core_state = 3'b001;
    tick();
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h05, 16'h0000}) begin
      errors++; $display("FAIL basic_req got %h exp %h", obs, {3'd1, 1'b1, 8'h05, 16'h0000});
    end
    core_state = 3'b000; current_pc = 8'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== {3'd1, 1'b1, 8'h05, 16'h0000}) begin
        errors++; $display("FAIL basic_hold%0d got %h exp %h", i, obs, {3'd1, 1'b1, 8'h05, 16'h0000});
      end
    end
    mem_read_ready = 1'b1; mem_read_data = 16'hA3C1;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    checks++;
    if (obs !== {3'd2, 1'b0, 8'h05, 16'hA3C1}) begin
      errors++; $display("FAIL basic_capture got %h exp %h", obs, {3'd2, 1'b0, 8'h05, 16'hA3C1});
    end
  endtask

  task automatic test_hygiene();
    core_state = 3'b001; current_pc = 8'h06;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== {3'd2, 1'b0, 8'h05, 16'hA3C1}) begin
        errors++; $display("FAIL fetched_no_req%0d got %h exp %h", i, obs, {3'd2, 1'b0, 8'h05, 16'hA3C1});
      end
    end
    core_state = 3'b010;
    tick();
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h05, 16'hA3C1}) begin
      errors++; $display("FAIL decode_to_idle got %h exp %h", obs, {3'd0, 1'b0, 8'h05, 16'hA3C1});
    end
    core_state = 3'b000; mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h05, 16'hA3C1}) begin
      errors++; $display("FAIL idle_ready_ignored got %h exp %h", obs, {3'd0, 1'b0, 8'h05, 16'hA3C1});
    end
  endtask

  task automatic test_immediate_ready();
    core_state = 3'b001; current_pc = 8'h20;
    tick();
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h20, 16'hA3C1}) begin
      errors++; $display("FAIL imm_req got %h exp %h", obs, {3'd1, 1'b1, 8'h20, 16'hA3C1});
    end
    core_state = 3'b010; mem_read_ready = 1'b1; mem_read_data = 16'h1234;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    checks++;
    if (obs !== {3'd2, 1'b0, 8'h20, 16'h1234}) begin
      errors++; $display("FAIL imm_capture got %h exp %h", obs, {3'd2, 1'b0, 8'h20, 16'h1234});
    end
    tick();
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h20, 16'h1234}) begin
      errors++; $display("FAIL imm_to_idle got %h exp %h", obs, {3'd0, 1'b0, 8'h20, 16'h1234});
    end
  endtask

  task automatic test_reset_mid_fetch();
    core_state = 3'b001; current_pc = 8'h80;
    tick();
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h80, 16'h1234}) begin
      errors++; $display("FAIL mid_req got %h exp %h", obs, {3'd1, 1'b1, 8'h80, 16'h1234});
    end
    core_state = 3'b000;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h00, 16'h0000}) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs, {3'd0, 1'b0, 8'h00, 16'h0000});
    end
    tick();
    @(negedge clk); reset = 1'b0;
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h00, 16'h0000}) begin
      errors++; $display("FAIL stray_ready got %h exp %h", obs, {3'd0, 1'b0, 8'h00, 16'h0000});
    end
    core_state = 3'b001; current_pc = 8'h81;
    tick();
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h81, 16'h0000}) begin
      errors++; $display("FAIL post_reset_req got %h exp %h", obs, {3'd1, 1'b1, 8'h81, 16'h0000});
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h0081; core_state = 3'b010;
    tick();
    mem_read_ready = 1'b0;
    tick();
    checks++;
    if (obs !== {3'd0, 1'b0, 8'h81, 16'h0081}) begin
      errors++; $display("FAIL post_reset_done got %h exp %h", obs, {3'd0, 1'b0, 8'h81, 16'h0081});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pcs   [2];
    logic [15:0] datas [2];
    pcs[0] = 8'hFE; pcs[1] = 8'hFF;
    datas[0] = 16'h1111; datas[1] = 16'h2222;
    for (int k = 0; k < 2; k++) begin
      core_state = 3'b001; current_pc = pcs[k];
      tick();
      checks++;
      if ({mem_read_valid, mem_read_address} !== {1'b1, pcs[k]}) begin
        errors++; $display("FAIL b2b_req%0d got %h exp %h", k, {mem_read_valid, mem_read_address}, {1'b1, pcs[k]});
      end
      core_state = 3'b010; mem_read_ready = 1'b1; mem_read_data = datas[k];
      tick();
      mem_read_ready = 1'b0;
      checks++;
      if ({fetcher_state, mem_read_valid, instruction} !== {3'd2, 1'b0, datas[k]}) begin
        errors++; $display("FAIL b2b_cap%0d got %h exp %h", k, {fetcher_state, mem_read_valid, instruction}, {3'd2, 1'b0, datas[k]});
      end
      tick();
      core_state = 3'b011; tick();
      core_state = 3'b101; tick();
      core_state = 3'b110; tick();
    end
  endtask

  task automatic test_cache();
    core_state = 3'b001; current_pc = 8'h10;
    tick();
    core_state = 3'b010; mem_read_ready = 1'b1; mem_read_data = 16'h5555;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    tick();
    core_state = 3'b001; current_pc = 8'h10;
    tick();
`ifdef FETCHER_LAST_INST_CACHE_EN
    checks++;
    if (obs !== {3'd2, 1'b0, 8'h10, 16'h5555}) begin
      errors++; $display("FAIL cache_hit got %h exp %h", obs, {3'd2, 1'b0, 8'h10, 16'h5555});
    end
`else
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h10, 16'h5555}) begin
      errors++; $display("FAIL refetch_req got %h exp %h", obs, {3'd1, 1'b1, 8'h10, 16'h5555});
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h5555;
    tick();
    mem_read_ready = 1'b0;
`endif
    core_state = 3'b010;
    tick();
    core_state = 3'b001; current_pc = 8'h11;
    tick();
    checks++;
    if (obs !== {3'd1, 1'b1, 8'h11, 16'h5555}) begin
      errors++; $display("FAIL miss_req got %h exp %h", obs, {3'd1, 1'b1, 8'h11, 16'h5555});
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h6666; core_state = 3'b010;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (obs !== {3'd2, 1'b0, 8'h11, 16'h6666}) begin
      errors++; $display("FAIL miss_cap got %h exp %h", obs, {3'd2, 1'b0, 8'h11, 16'h6666});
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hygiene();
    test_immediate_ready();
    test_reset_mid_fetch();
    test_back_to_back();
    test_cache();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
